// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : shared PS/2 host-transmit state encodings and command constants
// Rev 1.0
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } tx_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_DEFAULTS = 8'hF6;
    localparam logic [7:0] ACK          = 8'hFA;

    localparam int FILTER_LEN = 8;

    localparam logic [3:0] EDGE_PARITY = 4'd9;
    localparam logic [3:0] EDGE_STOP   = 4'd10;
    localparam logic [3:0] EDGE_ACK    = 4'd11;

    // Parity bit value that makes the 9-bit data+parity word odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// ps2_line_filter : 2-flop synchronizer, 8-sample stability filter and
//                   falling-edge detect for one PS/2 line
// Rev 1.0
// ============================================================================
module ps2_line_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic fall
);

    logic                  meta;
    logic                  sync;
    logic [FILTER_LEN-1:0] hist;

    // Level only moves once all samples agree; idle bus is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            hist  <= '1;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            meta <= line;
            sync <= meta;
            hist <= {hist[FILTER_LEN-2:0], sync};
            fall <= 1'b0;
            if (&hist) begin
                level <= 1'b1;
            end else if (~|hist) begin
                level <= 1'b0;
                fall  <= level;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// ps2_host_tx : PS/2 host-to-device command transmitter (inhibit, request,
//               device-clocked shift, ack check, timeout)
// Rev 1.0
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned INHIBIT_US = 120,
    parameter int unsigned TIMEOUT_US = 15000
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned CYC_PER_US  = CLK_HZ / 1_000_000;
    localparam int unsigned INHIBIT_CYC = INHIBIT_US * CYC_PER_US;
    localparam int unsigned TIMEOUT_CYC = TIMEOUT_US * CYC_PER_US;
    localparam int unsigned TMAX        = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int          TIMER_W     = $clog2(TMAX + 1);

    tx_state_t          state, state_n;
    logic [TIMER_W-1:0] timer, timer_n;
    logic [3:0]         n, n_n;
    logic [7:0]         tx_byte, tx_byte_n;
    logic               clk_oe_n, data_oe_n, done_n, err_n;
    logic               clk_lvl, clk_fall, data_lvl;
    logic [3:0]         edge_num;
    logic               timed_out;

    ps2_line_filter u_clk_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (ps2_clk),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_filter u_data_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .line  (ps2_data),
        .level (data_lvl),
        .fall  ()
    );

    assign tx_ready  = (state == ST_IDLE);
    assign tx_busy   = (state != ST_IDLE);
    assign edge_num  = n + 4'd1;
    assign timed_out = (timer == TIMER_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            n           <= '0;
            tx_byte     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            n           <= n_n;
            tx_byte     <= tx_byte_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            tx_done     <= done_n;
            tx_err      <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer + TIMER_W'(1);
        n_n       = n;
        tx_byte_n = tx_byte;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            ST_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                timer_n   = '0;
                n_n       = '0;
                if (tx_valid) begin
                    tx_byte_n = tx_data;
                    clk_oe_n  = 1'b1;
                    state_n   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (timer == TIMER_W'(INHIBIT_CYC - 1)) begin
                    data_oe_n = 1'b1;
                    state_n   = ST_REQ;
                end
            end
            ST_REQ: begin
                // Timeout is measured from the clock release that happens here.
                clk_oe_n = 1'b0;
                timer_n  = '0;
                state_n  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (timed_out) begin
                    data_oe_n = 1'b0;
                    err_n     = 1'b1;
                    state_n   = ST_IDLE;
                end else if (clk_fall) begin
                    n_n = edge_num;
                    if (edge_num <= 4'd8) begin
                        data_oe_n = ~tx_byte[n[2:0]];
                    end else if (edge_num == EDGE_PARITY) begin
                        data_oe_n = ~odd_parity(tx_byte);
                    end else if (edge_num == EDGE_STOP) begin
                        data_oe_n = 1'b0;
                    end else if (edge_num == EDGE_ACK) begin
                        if (data_lvl) begin
                            err_n   = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_WAIT_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (timed_out) begin
                    data_oe_n = 1'b0;
                    err_n     = 1'b1;
                    state_n   = ST_IDLE;
                end else if (clk_lvl && data_lvl) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
